// File: rtl/clk_en_gen.sv
// clk_en_gen: single-domain clock-enable generator.
//
// From clk_in1 it derives N_CH divided one-cycle enable strobes (ce) and
// near-50% duty level waveforms (lvl). Each channel has its own divide
// ratio and strobe phase. These are loaded through a valid/ready config
// port. Before the outputs are enabled, the block runs a lock sequence
// that mimics PLL lock/relock: IDLE -> WAIT (LOCK_CYCLES cycles) -> LOCKED.
// Every entry to LOCKED restarts all channel counters from 0, so the
// channels keep a deterministic relative phase.
//
// Ports:
//   clk_in1    in   sole clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   run        in   enable; 0 returns the block to IDLE
//   cfg_valid  in   config request
//   cfg_ready  out  config accept (low only while WAITing for lock)
//   cfg_ch     in   target channel (values >= N_CH are accepted and dropped)
//   cfg_div    in   divide ratio (0 is treated as 1)
//   cfg_phase  in   strobe position within the period (clamped to div-1)
//   locked     out  outputs valid and phase-aligned
//   ce         out  per-channel one-cycle enable strobe
//   lvl        out  per-channel level, high for ceil(div/2) cycles
module clk_en_gen #(
    parameter int N_CH        = 4,
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 2,
    parameter int LOCK_CYCLES = 16,
    parameter int CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk_in1,
    input  logic              reset_n,
    input  logic              run,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic [DIV_W-1:0]  cfg_phase,
    output logic              locked,
    output logic [N_CH-1:0]   ce,
    output logic [N_CH-1:0]   lvl
);

    localparam int LCW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_LOCKED
    } state_t;

    state_t           state_q,    state_d;
    logic [LCW-1:0]   lock_cnt_q, lock_cnt_d;
    logic             locked_q,   locked_d;
    logic [DIV_W-1:0] div_q   [N_CH];
    logic [DIV_W-1:0] div_d   [N_CH];
    logic [DIV_W-1:0] phase_q [N_CH];
    logic [DIV_W-1:0] phase_d [N_CH];
    logic [DIV_W-1:0] cnt_q   [N_CH];
    logic [DIV_W-1:0] cnt_d   [N_CH];

    logic             hs;
    logic [DIV_W-1:0] eff_div;
    logic [DIV_W-1:0] eff_phase;

    // WAIT is the only state that refuses configuration.
    assign cfg_ready = (state_q != ST_WAIT);
    assign hs        = cfg_valid & cfg_ready;
    assign locked    = locked_q;

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        div_d      = div_q;
        phase_d    = phase_q;
        cnt_d      = cnt_q;

        // A zero divide is promoted to 1; phase cannot exceed div-1.
        eff_div   = (cfg_div == '0) ? DIV_W'(1) : cfg_div;
        eff_phase = (cfg_phase > eff_div - DIV_W'(1)) ? eff_div - DIV_W'(1) : cfg_phase;

        // Out-of-range channel numbers match no entry, so the handshake
        // completes without writing anything.
        for (int i = 0; i < N_CH; i++) begin
            if (hs && (cfg_ch == CH_W'(i))) begin
                div_d[i]   = eff_div;
                phase_d[i] = eff_phase;
            end
        end

        // run=0 beats everything, including a relock request.
        if (!run) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d    = ST_WAIT;
                    lock_cnt_d = '0;
                end
                ST_WAIT: begin
                    if (lock_cnt_q == LCW'(LOCK_CYCLES - 1)) begin
                        state_d = ST_LOCKED;
                    end else begin
                        lock_cnt_d = lock_cnt_q + LCW'(1);
                    end
                end
                ST_LOCKED: begin
                    // A new configuration invalidates alignment: relock.
                    if (hs) begin
                        state_d    = ST_WAIT;
                        lock_cnt_d = '0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        locked_d = (state_d == ST_LOCKED);

        // Counters run only while staying in LOCKED; any other transition
        // (including entry to LOCKED) leaves them at 0 so all channels
        // restart together.
        for (int i = 0; i < N_CH; i++) begin
            if ((state_q == ST_LOCKED) && (state_d == ST_LOCKED)) begin
                if (cnt_q[i] >= div_q[i] - DIV_W'(1)) begin
                    cnt_d[i] = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + DIV_W'(1);
                end
            end else begin
                cnt_d[i] = '0;
            end
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples the
    // pre-edge value of every other flop, independent of statement order.
    always_ff @(posedge clk_in1 or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            lock_cnt_q <= '0;
            locked_q   <= 1'b0;
            // NOTE: the per-channel register arrays are reset on purpose:
            // the block must come out of reset at DEFAULT_DIV, phase 0.
            for (int i = 0; i < N_CH; i++) begin
                div_q[i]   <= DIV_W'(DEFAULT_DIV);
                phase_q[i] <= '0;
                cnt_q[i]   <= '0;
            end
        end else begin
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
            locked_q   <= locked_d;
            div_q      <= div_d;
            phase_q    <= phase_d;
            cnt_q      <= cnt_d;
        end
    end

    // Outputs are decoded purely from flops: no input-to-output path.
    // The +1 is done at DIV_W+1 bits so div = 2^DIV_W-1 does not wrap.
    always_comb begin
        ce  = '0;
        lvl = '0;
        for (int i = 0; i < N_CH; i++) begin
            ce[i]  = locked_q & (cnt_q[i] == phase_q[i]);
            lvl[i] = locked_q &
                     ({1'b0, cnt_q[i]} < (({1'b0, div_q[i]} + (DIV_W + 1)'(1)) >> 1));
        end
    end

endmodule
